pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard-detection and forwarding controller for the in-order pipelined processor. It tracks every in-flight register write in a DEPTH-entry shift tracker, generates operand-forwarding selects for the decode/issue stage, and stalls the issue stage when a result is not yet available (load-use). It also handles branch flushes and drives the register-file write port at retirement. It replaces the fixed four-mux forwarding arrangement of the 8-bit datapath with a per-operand, latency-aware generalisation that has stall, flush, and performance counters.

## Interface
- NREGS, 4: number of architectural registers; REGW = clog2(NREGS), minimum 1.
- DEPTH, 3: tracked stages after issue; stage DEPTH is the write-back stage. SELW = clog2(DEPTH+1).
- ALU_LAT, 1: first stage whose non-load result is forwardable.
- LD_LAT, 2: first stage whose load result is forwardable.
- FLUSH_DEPTH, 1: number of youngest stages (1..FLUSH_DEPTH) killed by flush.
- CNTW, 16: counter width.
- Legal parameter ranges: 1 ≤ ALU_LAT ≤ LD_LAT ≤ DEPTH; 0 ≤ FLUSH_DEPTH < DEPTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- issue_valid  in  1  instruction present at issue.
- issue_use1, issue_use2  in  1  operand 1/2 reads a register.
- issue_rs1, issue_rs2  in  REGW  source registers.
- issue_wr  in  1  instruction writes a register.
- issue_rd  in  REGW  destination register.
- issue_ld  in  1  result comes from memory.
- flush  in  1  taken branch resolved; kill younger work.
- issue_ack  out  1  instruction accepted this cycle.
- stall  out  1  issue must hold.
- fwd1_sel, fwd2_sel  out  SELW  0 = register file; k = forward from stage k.
- pend_mask  out  NREGS  bit r set if any valid tracked entry writes r.
- rf_we  out  1  write-back enable (stage DEPTH valid and wr).
- rf_wa  out  REGW  write-back address.
- stall_cnt  out  CNTW  saturating count of stalled cycles.
- retire_cnt  out  CNTW  wrapping count of retired instructions.

## Operation
- Tracker entry k (1..DEPTH) holds: valid, wr, rd, ld. Entry 1 is the youngest.
- Every clock edge the tracker shifts unconditionally:
  - entry 1 loads the issuing instruction if issue_ack = 1, otherwise a bubble (valid = 0);
  - entry k+1 loads entry k;
  - entry DEPTH retires.
- Per used operand with source s:
  - Find the smallest k where valid_k, wr_k, and rd_k == s.
  - No match: sel = 0.
  - Match and k ≥ (ld_k ? LD_LAT : ALU_LAT): sel = k.
  - Otherwise the operand is not ready.
  - Unused operands: sel = 0; they never stall.
- stall = issue_valid & (either used operand not ready) & ~flush.
- issue_ack = issue_valid & ~stall & ~flush.
- Write-back bypass: the register file writes at the clock edge, so a same-cycle read returns the old value. A match at stage DEPTH therefore forwards (sel = DEPTH) rather than reading the register file.
- Flush:
  - Entries 1..FLUSH_DEPTH are invalidated at the edge, instead of being shifted into the next entry.
  - The issuing instruction is discarded.
  - Older entries shift and retire normally.
- Flush and stall asserted together: flush wins. stall = 0, issue_ack = 0, stall_cnt is not incremented.
- stall_cnt increments on each stall cycle and holds at all-ones.
- retire_cnt increments when entry DEPTH is valid and wraps modulo 2^CNTW; this includes non-writing instructions.

## Timing
- Reset (asynchronous, any time, including mid-stall): all valid bits = 0, counters = 0. All outputs read 0 from the assertion onward.
- stall, issue_ack, fwd*_sel, pend_mask, rf_we, rf_wa: combinational from inputs and tracker state, with no added latency.
- Tracker updates and counters: posedge only.
- An instruction issued in cycle t occupies entry k during cycle t+k and writes back at the end of cycle t+DEPTH.
- Load-use stall with defaults: 1 cycle when the dependent instruction issues immediately after the load; 0 cycles if one instruction intervenes.
- Duplicate destinations in flight: the youngest match wins.

## Test plan
- Reset mid-operation: three entries valid, assert reset → rf_we = 0, pend_mask = 0000, stall_cnt = 0, retire_cnt = 0 immediately; tracker still empty after release.
- ALU back-to-back: issue wr rd = 1 (ALU), next cycle issue use1 rs1 = 1 → fwd1_sel = 1, stall = 0, issue_ack = 1.
- Load-use: issue ld rd = 2, next cycle use2 rs2 = 2 → stall = 1 for exactly 1 cycle, stall_cnt = 1; following cycle fwd2_sel = 2, issue_ack = 1.
- Write-back bypass: issue wr rd = 3, two bubbles, then use1 rs1 = 3 → fwd1_sel = 3, rf_we = 1, rf_wa = 3 in the same cycle; retire_cnt = 1 next cycle.
- Youngest wins: wr rd = 1 then wr rd = 1 back-to-back, then use1 rs1 = 1 → fwd1_sel = 1, not 2.
- Flush: issue wr rd = 1, next cycle flush = 1 with issue_valid = 1 → issue_ack = 0; next cycle pend_mask = 0000; rf_we never asserts for that entry; retire_cnt unchanged after DEPTH cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection / operand forwarding controller: a DEPTH-entry in-flight write
// tracker drives forwarding selects, load-use stalls, branch flushes and write-back.
module pipe_hazard_ctrl #(
  parameter int NREGS       = 4,
  parameter int DEPTH       = 3,
  parameter int ALU_LAT     = 1,
  parameter int LD_LAT      = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNTW        = 16,
  localparam int REGW       = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int SELW       = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_use1,
  input  logic              issue_use2,
  input  logic [REGW-1:0]   issue_rs1,
  input  logic [REGW-1:0]   issue_rs2,
  input  logic              issue_wr,
  input  logic [REGW-1:0]   issue_rd,
  input  logic              issue_ld,
  input  logic              flush,
  output logic              issue_ack,
  output logic              stall,
  output logic [SELW-1:0]   fwd1_sel,
  output logic [SELW-1:0]   fwd2_sel,
  output logic [NREGS-1:0]  pend_mask,
  output logic              rf_we,
  output logic [REGW-1:0]   rf_wa,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   retire_cnt
);

  // Tracker: index 1 is the youngest stage, index DEPTH is write-back.
  logic [DEPTH:1]           r_vld;
  logic [DEPTH:1]           r_wr;
  logic [DEPTH:1]           r_ld;
  logic [DEPTH:1][REGW-1:0] r_rd;
  logic [CNTW-1:0]          r_stall_cnt;
  logic [CNTW-1:0]          r_retire_cnt;

  logic [SELW:0]            w_lk1;
  logic [SELW:0]            w_lk2;
  logic                     w_nr1;
  logic                     w_nr2;
  logic                     w_stall;
  logic                     w_ack;
  logic [NREGS-1:0]         w_pend;

  // Returns {not_ready, sel}; scanning oldest to youngest lets the youngest match win.
  function automatic logic [SELW:0] lookup(
    input logic [DEPTH:1]           vld,
    input logic [DEPTH:1]           wr,
    input logic [DEPTH:1]           ld,
    input logic [DEPTH:1][REGW-1:0] rd,
    input logic [REGW-1:0]          src
  );
    logic [SELW:0] res;
    res = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld[k] && wr[k] && (rd[k] == src)) begin
        if (k >= (ld[k] ? LD_LAT : ALU_LAT)) res = {1'b0, SELW'(k)};
        else                                 res = {1'b1, {SELW{1'b0}}};
      end
    end
    return res;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  always_comb begin
    w_lk1   = lookup(r_vld, r_wr, r_ld, r_rd, issue_rs1);
    w_lk2   = lookup(r_vld, r_wr, r_ld, r_rd, issue_rs2);
    w_nr1   = issue_use1 & w_lk1[SELW];
    w_nr2   = issue_use2 & w_lk2[SELW];
    // Flush overrides stall; reset forces every combinational output low.
    w_stall = issue_valid & (w_nr1 | w_nr2) & ~flush & ~reset;
    w_ack   = issue_valid & ~w_stall & ~flush & ~reset;
  end

  always_comb begin
    w_pend = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (r_vld[k] && r_wr[k]) w_pend[r_rd[k]] = 1'b1;
    end
  end

  assign stall      = w_stall;
  assign issue_ack  = w_ack;
  assign fwd1_sel   = issue_use1 ? w_lk1[SELW-1:0] : '0;
  assign fwd2_sel   = issue_use2 ? w_lk2[SELW-1:0] : '0;
  assign pend_mask  = w_pend;
  assign rf_we      = r_vld[DEPTH] & r_wr[DEPTH];
  assign rf_wa      = rf_we ? r_rd[DEPTH] : '0;
  assign stall_cnt  = r_stall_cnt;
  assign retire_cnt = r_retire_cnt;

  // Control: valid bits and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld        <= '0;
      r_stall_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      r_vld[1] <= w_ack;
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k+1] <= r_vld[k] & ~(flush && (k <= FLUSH_DEPTH));
      end
      if (w_stall)      r_stall_cnt  <= sat_inc(r_stall_cnt);
      if (r_vld[DEPTH]) r_retire_cnt <= r_retire_cnt + CNTW'(1);
    end
  end

  // Payload: qualified by r_vld, so it needs no reset
  always_ff @(posedge clock) begin
    r_wr[1] <= issue_wr;
    r_ld[1] <= issue_ld;
    r_rd[1] <= issue_rd;
    for (int k = 1; k < DEPTH; k++) begin
      r_wr[k+1] <= r_wr[k];
      r_ld[k+1] <= r_ld[k];
      r_rd[k+1] <= r_rd[k];
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a timestamp-based in-flight model predicts
// each cycle's outputs; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;
  localparam int NREGS = 4, DEPTH = 3, ALU_LAT = 1, LD_LAT = 2, FLUSH_DEPTH = 1, CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 0, issue_use1 = 0, issue_use2 = 0, issue_wr = 0, issue_ld = 0, flush = 0;
  logic [1:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0;
  logic issue_ack, stall, rf_we;
  logic [1:0] fwd1_sel, fwd2_sel, rf_wa;
  logic [3:0] pend_mask;
  logic [CNTW-1:0] stall_cnt, retire_cnt;

  pipe_hazard_ctrl #(.NREGS(NREGS), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT),
                     .FLUSH_DEPTH(FLUSH_DEPTH), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_use1(issue_use1),
    .issue_use2(issue_use2), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_wr(issue_wr), .issue_rd(issue_rd), .issue_ld(issue_ld), .flush(flush),
    .issue_ack(issue_ack), .stall(stall), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .pend_mask(pend_mask), .rf_we(rf_we), .rf_wa(rf_wa), .stall_cnt(stall_cnt),
    .retire_cnt(retire_cnt));

  always #5 clock = ~clock;

  typedef struct { int ic; bit wr; bit [1:0] rd; bit ld; } rec_t;
  typedef struct { bit stall, ack, we; int sel1, sel2, pend, wa, scnt, rcnt; } exp_t;

  rec_t inflight[$];
  exp_t exp_q[$];
  int cyc = 0;
  int m_scnt = 0, m_rcnt = 0;
  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Youngest in-flight writer of s decides forwarding by its age (cycles since issue).
  function automatic void lookup(input bit u, input bit [1:0] s, output int sel, output bit nr);
    int best = DEPTH + 1;
    bit bld = 0;
    foreach (inflight[i]) begin
      if (inflight[i].wr && inflight[i].rd == s && (cyc - inflight[i].ic) < best) begin
        best = cyc - inflight[i].ic;
        bld  = inflight[i].ld;
      end
    end
    sel = 0;
    nr  = 0;
    if (u && best <= DEPTH) begin
      if (best >= (bld ? LD_LAT : ALU_LAT)) sel = best;
      else nr = 1;
    end
  endfunction

  task automatic step(input bit rst, input bit v, input bit u1, input bit [1:0] s1,
                      input bit u2, input bit [1:0] s2, input bit w, input bit [1:0] d,
                      input bit l, input bit fl);
    exp_t e;
    rec_t keep[$];
    bit nr1, nr2, retiring;
    @(posedge clock);
    #1;
    issue_valid = v; issue_use1 = u1; issue_rs1 = s1; issue_use2 = u2; issue_rs2 = s2;
    issue_wr = w; issue_rd = d; issue_ld = l; flush = fl; reset = rst;
    cyc++;
    e = '{default: 0};
    if (rst) begin
      inflight.delete();
      m_scnt = 0;
      m_rcnt = 0;
      exp_q.push_back(e);
      return;
    end
    while (inflight.size() > 0 && (cyc - inflight[0].ic) > DEPTH) void'(inflight.pop_front());
    lookup(u1, s1, e.sel1, nr1);
    lookup(u2, s2, e.sel2, nr2);
    e.stall = v && (nr1 || nr2) && !fl;
    e.ack   = v && !e.stall && !fl;
    retiring = 0;
    foreach (inflight[i]) begin
      if (inflight[i].wr) e.pend |= (1 << inflight[i].rd);
      if ((cyc - inflight[i].ic) == DEPTH) begin
        retiring = 1;
        e.we = inflight[i].wr;
        e.wa = inflight[i].wr ? inflight[i].rd : 0;
      end
    end
    e.scnt = m_scnt;
    e.rcnt = m_rcnt;
    exp_q.push_back(e);
    // Model state after the coming edge
    if (e.stall && m_scnt < CMAX) m_scnt++;
    if (retiring) m_rcnt = (m_rcnt + 1) & CMAX;
    if (fl) begin
      foreach (inflight[i]) if ((cyc - inflight[i].ic) > FLUSH_DEPTH) keep.push_back(inflight[i]);
      inflight = keep;
    end
    if (e.ack) inflight.push_back('{cyc, w, d, l});
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stall",      32'(stall),      32'(e.stall));
      check("issue_ack",  32'(issue_ack),  32'(e.ack));
      check("fwd1_sel",   32'(fwd1_sel),   32'(e.sel1));
      check("fwd2_sel",   32'(fwd2_sel),   32'(e.sel2));
      check("pend_mask",  32'(pend_mask),  32'(e.pend));
      check("rf_we",      32'(rf_we),      32'(e.we));
      check("rf_wa",      32'(rf_wa),      32'(e.wa));
      check("stall_cnt",  32'(stall_cnt),  32'(e.scnt));
      check("retire_cnt", 32'(retire_cnt), 32'(e.rcnt));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 1, 1, 1, 1, 2, 1, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // ALU back-to-back
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    // Load-use: stall once, then forward from stage 2
    step(0, 1, 0, 0, 0, 0, 1, 2, 1, 0);
    step(0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 2, 0, 0, 0, 0);
    repeat (3) idle();
    // Write-back bypass
    step(0, 1, 0, 0, 0, 0, 1, 3, 0, 0);
    idle(); idle();
    step(0, 1, 1, 3, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    // Youngest duplicate wins
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();
    // Flush kills the youngest entry and the issuing instruction
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0, 1, 2, 0, 1);
    repeat (4) idle();
    // Reset with three entries valid
    repeat (3) step(0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
    step(1, 1, 1, 2, 0, 0, 1, 0, 0, 0);
    idle(); idle();
    // Randomized traffic with occasional flushes and resets; counters saturate/wrap
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           2'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
           2'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
    end
    idle();
    @(negedge clock);
    @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
